// File: rtl/mips32_mem_responder.sv
// Shared single-port instruction/data memory behind two req/ack ports.
// Data accesses win by default; a burst limit forces a pending fetch through.
module mips32_mem_responder #(
    parameter int ADDR_W       = 10,
    parameter int WAIT_STATES  = 1,
    parameter int DM_BURST_MAX = 2
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;
    logic [7:0]  burst_cnt;
    logic [7:0]  burst_cnt_next;
    logic        grant_dm;
    logic        grant_if;

    logic        lat_dm;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              range_err;
    logic [ADDR_W-1:0] mem_idx;

    assign range_err = (lat_addr[31:ADDR_W] != '0);
    assign mem_idx   = lat_addr[ADDR_W-1:0];
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        burst_cnt_next = burst_cnt;
        grant_dm       = 1'b0;
        grant_if       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dm_req && (burst_cnt < 8'(DM_BURST_MAX))) begin
                    grant_dm = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end else if (dm_req) begin
                    grant_dm = 1'b1;
                end

                // The burst count only grows while a fetch is actually being held off.
                if (grant_dm) begin
                    if (!if_req) begin
                        burst_cnt_next = '0;
                    end else if (burst_cnt < 8'(DM_BURST_MAX)) begin
                        burst_cnt_next = burst_cnt + 8'd1;
                    end
                end
                if (grant_if) begin
                    burst_cnt_next = '0;
                end

                if (grant_dm || grant_if) begin
                    wait_cnt_next = 4'(WAIT_STATES);
                    state_next    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            err       <= 1'b0;
            lat_dm    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            burst_cnt <= burst_cnt_next;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;

            if (grant_dm || grant_if) begin
                lat_dm    <= grant_dm;
                lat_we    <= grant_dm & dm_we;
                lat_addr  <= grant_dm ? dm_addr : if_addr;
                lat_wdata <= dm_wdata;
            end

            if (state == ST_RESP) begin
                err <= range_err;
                if (lat_dm) begin
                    dm_ack   <= 1'b1;
                    dm_rdata <= (range_err || lat_we) ? 32'd0 : mem[mem_idx];
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= range_err ? 32'd0 : mem[mem_idx];
                end
            end
        end
    end

    // Storage is left unreset; a reset during WAIT leaves state IDLE so the write never fires.
    always_ff @(posedge clk1) begin
        if ((state == ST_RESP) && lat_dm && lat_we && !range_err) begin
            mem[mem_idx] <= lat_wdata;
        end
    end

endmodule
